// File: rtl/alarm_unit_if.sv
// ============================================================================
//  alarm_unit_if
//  Bundles the alarm stage's time/control inputs and its status outputs.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_unit_if;
    logic        sec_tick;
    logic [16:0] cur_secs;
    logic        set_en;
    logic [16:0] set_secs;
    logic        arm_toggle;
    logic        stop_req;
    logic        snooze_req;
    logic [16:0] alarm_secs;
    logic        armed;
    logic        ringing;
    logic        snoozed;
    logic        buzzer;
    logic        set_err;

    modport master (
        output sec_tick, cur_secs, set_en, set_secs, arm_toggle, stop_req, snooze_req,
        input  alarm_secs, armed, ringing, snoozed, buzzer, set_err
    );

    modport slave (
        input  sec_tick, cur_secs, set_en, set_secs, arm_toggle, stop_req, snooze_req,
        output alarm_secs, armed, ringing, snoozed, buzzer, set_err
    );
endinterface

`default_nettype wire

// File: rtl/alarm_unit.sv
// ============================================================================
//  alarm_unit
//  Programmable alarm: fires on a seconds-of-day match, handles stop, snooze
//  and auto-timeout, and drives a buzzer square wave plus status flags.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_unit #(
    parameter int DAY_SECS    = 86400,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int TONE_DIV    = 50000
) (
    input  logic         clk,
    input  logic         rst,
    alarm_unit_if.slave  bus
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CNT_W-1:0]  C_RING      = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0]  C_SNOOZE    = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [TONE_W-1:0] C_TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [TONE_W-1:0] C_TONE_ONE  = TONE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TONE_W-1:0]  r_tone;
    logic               r_buzzer;
    logic [16:0]        r_alarm;
    logic [16:0]        r_prev;
    logic               r_set_err;
    logic               r_armed;
    logic               r_ringing;
    logic               r_snoozed;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TONE_W-1:0]  w_tone_nxt;
    logic               w_buzzer_nxt;
    logic [16:0]        w_alarm_nxt;
    logic               w_set_err_nxt;
    logic               w_match;
    logic               w_set_ok;

    // Edge-qualified match: a freshly loaded alarm equal to "now" must not fire.
    assign w_match  = (bus.cur_secs == r_alarm) && (r_prev != bus.cur_secs);
    assign w_set_ok = (32'(bus.set_secs) < 32'(DAY_SECS));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_alarm_nxt   = r_alarm;
        w_set_err_nxt = 1'b0;
        w_tone_nxt    = '0;
        w_buzzer_nxt  = 1'b0;

        if (bus.arm_toggle) begin
            w_state_nxt = (r_state == S_IDLE) ? S_ARMED : S_IDLE;
        end else if (bus.set_en) begin
            if (w_set_ok) begin
                w_alarm_nxt = bus.set_secs;
                if (r_state == S_RINGING || r_state == S_SNOOZE)
                    w_state_nxt = S_ARMED;
            end else begin
                w_set_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = S_RINGING;
                        w_cnt_nxt   = C_RING;
                    end
                end
                S_RINGING: begin
                    if (bus.stop_req) begin
                        w_state_nxt = S_ARMED;
                    end else if (bus.snooze_req) begin
                        w_state_nxt = S_SNOOZE;
                        w_cnt_nxt   = C_SNOOZE;
                    end else if (bus.sec_tick) begin
                        if (r_cnt == C_CNT_ONE)
                            w_state_nxt = S_ARMED;
                        else
                            w_cnt_nxt = r_cnt - C_CNT_ONE;
                    end
                end
                S_SNOOZE: begin
                    if (bus.stop_req) begin
                        w_state_nxt = S_ARMED;
                    end else if (bus.sec_tick) begin
                        if (r_cnt == C_CNT_ONE) begin
                            w_state_nxt = S_RINGING;
                            w_cnt_nxt   = C_RING;
                        end else begin
                            w_cnt_nxt = r_cnt - C_CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Tone only runs while staying in RINGING; any (re-)entry restarts it from 0.
        if (r_state == S_RINGING && w_state_nxt == S_RINGING) begin
            if (r_tone == C_TONE_LAST) begin
                w_tone_nxt   = '0;
                w_buzzer_nxt = ~r_buzzer;
            end else begin
                w_tone_nxt   = r_tone + C_TONE_ONE;
                w_buzzer_nxt = r_buzzer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tone    <= '0;
            r_buzzer  <= 1'b0;
            r_alarm   <= '0;
            r_prev    <= bus.cur_secs;
            r_set_err <= 1'b0;
            r_armed   <= 1'b0;
            r_ringing <= 1'b0;
            r_snoozed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tone    <= w_tone_nxt;
            r_buzzer  <= w_buzzer_nxt;
            r_alarm   <= w_alarm_nxt;
            r_prev    <= bus.cur_secs;
            r_set_err <= w_set_err_nxt;
            r_armed   <= (w_state_nxt != S_IDLE);
            r_ringing <= (w_state_nxt == S_RINGING);
            r_snoozed <= (w_state_nxt == S_SNOOZE);
        end
    end

    assign bus.alarm_secs = r_alarm;
    assign bus.armed      = r_armed;
    assign bus.ringing    = r_ringing;
    assign bus.snoozed    = r_snoozed;
    assign bus.buzzer     = r_buzzer;
    assign bus.set_err    = r_set_err;

endmodule

`default_nettype wire

// File: tb/tb_alarm_unit.sv
// ============================================================================
//  tb_alarm_unit
//  Directed-vector bench for alarm_unit with a queue-based scoreboard.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_unit;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    alarm_unit_if bus ();

    alarm_unit #(
        .DAY_SECS    (86400),
        .RING_SECS   (3),
        .SNOOZE_SECS (2),
        .TONE_DIV    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // flags = {armed, ringing, snoozed, buzzer, set_err}
    typedef struct {
        int          cyc;
        string       nm;
        logic [16:0] alarm;
        logic [4:0]  flags;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the output bundle whenever an expectation falls due.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = q[0];
            act = {bus.armed, bus.ringing, bus.snoozed, bus.buzzer, bus.set_err};
            if (e.cyc <= cyc) begin
                void'(q.pop_front());
                n_tests++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
                end else if (act !== e.flags || bus.alarm_secs !== e.alarm) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got alarm=%0d flags(arm,ring,snz,buz,err)=%b, want alarm=%0d flags=%b",
                             e.nm, cyc, bus.alarm_secs, act, e.alarm, e.flags);
                end
            end
        end
    end

    task automatic go(input string nm, input logic [16:0] ea, input logic [4:0] ef);
        exp_t e;
        e.cyc   = cyc + 1;
        e.nm    = nm;
        e.alarm = ea;
        e.flags = ef;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.sec_tick   = 1'b0;
        bus.set_en     = 1'b0;
        bus.arm_toggle = 1'b0;
        bus.stop_req   = 1'b0;
        bus.snooze_req = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.cur_secs   = 17'd50;
        bus.set_secs   = 17'd0;
        bus.sec_tick   = 1'b0;
        bus.set_en     = 1'b0;
        bus.arm_toggle = 1'b0;
        bus.stop_req   = 1'b0;
        bus.snooze_req = 1'b0;

        go("reset", 17'd0, 5'b00000);
        rst = 1'b0;

        // Load and fire
        bus.set_en = 1'b1; bus.set_secs = 17'd100;
        go("load", 17'd100, 5'b00000);
        bus.arm_toggle = 1'b1;
        go("arm", 17'd100, 5'b10000);
        bus.cur_secs = 17'd99;
        go("pre_fire", 17'd100, 5'b10000);
        bus.cur_secs = 17'd100;
        go("fire", 17'd100, 5'b11000);
        for (int k = 1; k <= 9; k++) begin
            bus.sec_tick = (k == 2 || k == 5 || k == 9);
            if (k == 9) go("auto_stop", 17'd100, 5'b10000);
            else        go("ring_tone", 17'd100, {3'b110, (k >= 4 && k <= 7), 1'b0});
        end

        // Snooze, re-ring, stop
        bus.cur_secs = 17'd101;
        go("rearm_gap", 17'd100, 5'b10000);
        bus.cur_secs = 17'd100;
        go("fire2", 17'd100, 5'b11000);
        bus.snooze_req = 1'b1;
        go("snooze", 17'd100, 5'b10100);
        bus.sec_tick = 1'b1;
        go("snooze_t1", 17'd100, 5'b10100);
        bus.snooze_req = 1'b1;
        go("snooze_ign", 17'd100, 5'b10100);
        bus.sec_tick = 1'b1;
        go("rering", 17'd100, 5'b11000);
        go("rering_hold", 17'd100, 5'b11000);
        bus.stop_req = 1'b1;
        go("stop", 17'd100, 5'b10000);

        // Invalid set
        bus.set_en = 1'b1; bus.set_secs = 17'd86400;
        go("bad_set", 17'd100, 5'b10001);
        go("bad_set_clr", 17'd100, 5'b10000);

        // No-fire: alarm loaded equal to current time
        bus.cur_secs = 17'd500;
        go("move_500", 17'd100, 5'b10000);
        bus.set_en = 1'b1; bus.set_secs = 17'd500;
        go("set_eq_now", 17'd500, 5'b10000);
        for (int k = 0; k < 3; k++) go("hold_eq", 17'd500, 5'b10000);

        // No-fire: disarmed sweep through alarm time
        bus.arm_toggle = 1'b1;
        go("disarm", 17'd500, 5'b00000);
        bus.set_en = 1'b1; bus.set_secs = 17'd100;
        go("set_idle", 17'd100, 5'b00000);
        for (int s = 99; s <= 101; s++) begin
            bus.cur_secs = 17'(s);
            go("idle_sweep", 17'd100, 5'b00000);
        end

        // Midnight wrap
        bus.set_en = 1'b1; bus.set_secs = 17'd0;
        go("set_zero", 17'd0, 5'b00000);
        bus.arm_toggle = 1'b1;
        go("arm_zero", 17'd0, 5'b10000);
        bus.cur_secs = 17'd86399;
        go("pre_mid", 17'd0, 5'b10000);
        bus.cur_secs = 17'd0;
        go("mid_fire", 17'd0, 5'b11000);

        // Priority: arm_toggle beats match
        bus.stop_req = 1'b1;
        go("mid_stop", 17'd0, 5'b10000);
        bus.cur_secs = 17'd86399;
        go("pre_prio", 17'd0, 5'b10000);
        bus.cur_secs = 17'd0; bus.arm_toggle = 1'b1;
        go("prio_arm", 17'd0, 5'b00000);
        go("prio_noring", 17'd0, 5'b00000);

        // Reset mid-ring
        bus.set_en = 1'b1; bus.set_secs = 17'd100;
        go("set_r", 17'd100, 5'b00000);
        bus.arm_toggle = 1'b1;
        go("arm_r", 17'd100, 5'b10000);
        bus.cur_secs = 17'd99;
        go("pre_r", 17'd100, 5'b10000);
        bus.cur_secs = 17'd100;
        go("fire_r", 17'd100, 5'b11000);
        for (int k = 1; k <= 4; k++)
            go("ring_r", 17'd100, {3'b110, (k == 4), 1'b0});
        rst = 1'b1;
        go("rst_ring", 17'd0, 5'b00000);
        rst = 1'b0;
        go("post_rst", 17'd0, 5'b00000);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
